// File: rtl/mult_pkg.sv
// Shared definitions for the radix-2 Booth sequential multiplier.
// Contents:
//   state_e      - controller states (idle, Booth stepping, result/done cycle)
//   BoothAdd/Sub - {Q[0], Q-1} recode patterns that add or subtract the multiplicand
//   cnt_width()  - step-counter width for a given operand width
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] BoothAdd = 2'b01;
    localparam logic [1:0] BoothSub = 2'b10;

    // The counter must hold 0..N, so this width is always sufficient.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/booth_mult_datapath.sv
// Booth multiplier datapath: multiplicand (M), accumulator (Acc), multiplier (Q),
// the Q-1 bit, the add/sub unit, the arithmetic shifter and the product register.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   load_i          - capture operands and clear Acc/Q-1
//   step_i          - run one Booth step (recode, add/sub, arithmetic shift)
//   latch_i         - capture the product into s_o; asserted together with the
//                     final step_i so the stored value includes that step
//   signed_i        - operand interpretation used at load
//   a_i, b_i        - multiplicand and multiplier
//   s_o             - registered 2N-bit product
module booth_mult_datapath
    import mult_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             latch_i,
    input  logic             signed_i,
    input  logic [N-1:0]     a_i,
    input  logic [N-1:0]     b_i,
    output logic [2*N-1:0]   s_o
);

    logic [N+1:0]   m_q, m_d;
    logic [N+1:0]   acc_q, acc_d;
    logic [N:0]     q_q, q_d;
    logic           qm1_q, qm1_d;
    logic [2*N-1:0] s_q, s_d;

    logic [N+1:0]   acc_sum;
    logic [N+1:0]   acc_sh;
    logic [N:0]     q_sh;
    logic           qm1_sh;
    logic           a_ext, b_ext;

    // Extension bit: sign in signed mode, zero otherwise. Treating both modes as
    // (N+1)-bit two's complement lets one Booth sequence serve both.
    assign a_ext = signed_i & a_i[N-1];
    assign b_ext = signed_i & b_i[N-1];

    always_comb begin
        acc_sum = acc_q;
        case ({q_q[0], qm1_q})
            BoothAdd: acc_sum = acc_q + m_q;
            BoothSub: acc_sum = acc_q - m_q;
            default:  acc_sum = acc_q;
        endcase

        // Arithmetic right shift of {Acc, Q, Q-1}, replicating the Acc MSB.
        {acc_sh, q_sh, qm1_sh} = {acc_sum[N+1], acc_sum, q_q};

        m_d   = m_q;
        acc_d = acc_q;
        q_d   = q_q;
        qm1_d = qm1_q;
        s_d   = s_q;

        if (load_i) begin
            m_d   = {a_ext, a_ext, a_i};
            acc_d = '0;
            q_d   = {b_ext, b_i};
            qm1_d = 1'b0;
        end else if (step_i) begin
            acc_d = acc_sh;
            q_d   = q_sh;
            qm1_d = qm1_sh;
        end

        // Low 2N bits of the post-shift {Acc, Q}.
        if (latch_i) begin
            s_d = {acc_sh[N-2:0], q_sh};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q   <= '0;
            acc_q <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            s_q   <= '0;
        end else begin
            m_q   <= m_d;
            acc_q <= acc_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
            s_q   <= s_d;
        end
    end

    assign s_o = s_q;

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, N-bit operands, 2N-bit product.
// Controller (FSM + step counter) lives here; arithmetic is in booth_mult_datapath.
// A product takes N+1 Booth steps; done pulses one cycle, N+1 cycles after accept.
// Ports:
//   clk, reset_n   - rising-edge clock, asynchronous active-low reset
//   start          - request; only honoured in idle
//   signed_mode    - 1: two's complement operands, 0: unsigned (captured with start)
//   A_in, B_in     - multiplicand, multiplier (captured with start)
//   busy           - high while calculating and during the done cycle
//   done           - one-cycle completion pulse (registered)
//   S              - product, held until the next completion
module booth_mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [N-1:0]     A_in,
    input  logic [N-1:0]     B_in,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   S
);

    localparam int unsigned      CntW    = cnt_width(N);
    localparam logic [CntW-1:0]  LastCnt = CntW'(N);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            done_q;

    logic load, step, latch;

    always_comb begin
        load  = (state_q == StIdle) && start;
        step  = (state_q == StCalc);
        // Final step (N+1) happens when the counter reads N.
        latch = step && (cnt_q == LastCnt);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StCalc;
                        cnt_q   <= '0;
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    booth_mult_datapath #(
        .N (N)
    ) u_datapath (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .load_i   (load),
        .step_i   (step),
        .latch_i  (latch),
        .signed_i (signed_mode),
        .a_i      (A_in),
        .b_i      (B_in),
        .s_o      (S)
    );

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
module tb_booth_mult_seq;

    logic clk;
    logic rst_n;

    // N=8 instance: directed vectors and timing checks
    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] s8;

    // N=4/16/32 instances share operand buses
    logic        start4, start16, start32, sm_g;
    logic [31:0] a_g, b_g;
    logic        busy4, done4, busy16, done16, busy32, done32;
    logic [7:0]  s4;
    logic [31:0] s16;
    logic [63:0] s32;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    booth_mult_seq #(.N(8)) dut8 (
        .clk(clk), .reset_n(rst_n), .start(start8), .signed_mode(sm8),
        .A_in(a8), .B_in(b8), .busy(busy8), .done(done8), .S(s8)
    );
    booth_mult_seq #(.N(4)) dut4 (
        .clk(clk), .reset_n(rst_n), .start(start4), .signed_mode(sm_g),
        .A_in(a_g[3:0]), .B_in(b_g[3:0]), .busy(busy4), .done(done4), .S(s4)
    );
    booth_mult_seq #(.N(16)) dut16 (
        .clk(clk), .reset_n(rst_n), .start(start16), .signed_mode(sm_g),
        .A_in(a_g[15:0]), .B_in(b_g[15:0]), .busy(busy16), .done(done16), .S(s16)
    );
    booth_mult_seq #(.N(32)) dut32 (
        .clk(clk), .reset_n(rst_n), .start(start32), .signed_mode(sm_g),
        .A_in(a_g), .B_in(b_g), .busy(busy32), .done(done32), .S(s32)
    );

    typedef struct {
        logic        sm;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] s;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference product for an n-bit operand pair, masked to 2n bits.
    function automatic logic [63:0] ref_mul(input int n, input logic sm,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] am, bm, mask;
        longint sa, sb, p;
        am = {32'd0, a} & ((64'd1 << n) - 64'd1);
        bm = {32'd0, b} & ((64'd1 << n) - 64'd1);
        sa = longint'(am);
        sb = longint'(bm);
        if (sm && am[n-1]) sa = sa - (longint'(1) << n);
        if (sm && bm[n-1]) sb = sb - (longint'(1) << n);
        p = sa * sb;
        mask = (n == 32) ? '1 : ((64'd1 << (2 * n)) - 64'd1);
        return logic'(1'b1) ? (64'(p) & mask) : 64'd0;
    endfunction

    // One N=8 operation: returns product seen with done, done latency (cycles after
    // accept edge), busy cycle count and number of done cycles.
    task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] s, output int lat, output int nbusy,
                       output int ndone);
        @(negedge clk);
        sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
        @(negedge clk);   // accept edge T has passed; now in cycle 0
        start8 = 1'b0;
        lat = -1; nbusy = 0; ndone = 0; s = 16'hxxxx;
        for (int i = 0; i < 16; i++) begin
            if (busy8) nbusy++;
            if (done8) begin
                ndone++;
                if (lat < 0) begin
                    lat = i;
                    s = s8;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic op_gen(input int n, input logic sm, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] s, output bit got);
        logic d;
        @(negedge clk);
        sm_g = sm; a_g = a; b_g = b;
        case (n)
            4:       start4 = 1'b1;
            16:      start16 = 1'b1;
            default: start32 = 1'b1;
        endcase
        @(negedge clk);
        start4 = 1'b0; start16 = 1'b0; start32 = 1'b0;
        got = 1'b0;
        s = '0;
        for (int i = 0; i < n + 8; i++) begin
            case (n)
                4:       d = done4;
                16:      d = done16;
                default: d = done32;
            endcase
            if (d) begin
                case (n)
                    4:       s = {56'd0, s4};
                    16:      s = {32'd0, s16};
                    default: s = s32;
                endcase
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t        vecs[10];
        logic [15:0] s;
        logic [63:0] sg;
        bit          got;
        int          lat, nbusy, ndone, first, second, dones;
        logic        bz10, bz11;
        logic [15:0] s_first, s_second;
        logic [31:0] ra, rb;

        vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[3] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[4] = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
        vecs[5] = '{1'b0, 8'd3,  8'd5,  16'd15};
        vecs[6] = '{1'b1, 8'hFD, 8'd5,  16'hFFF1};   // -3 * 5
        vecs[7] = '{1'b1, 8'h7F, 8'h80, 16'hC080};   // 127 * -128
        vecs[8] = '{1'b0, 8'h7F, 8'h80, 16'h3F80};
        vecs[9] = '{1'b1, 8'h00, 8'h9C, 16'h0000};

        rst_n = 1'b0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; start16 = 1'b0; start32 = 1'b0; sm_g = 1'b0; a_g = '0; b_g = '0;
        #1;
        check("reset_busy", {63'd0, busy8}, 64'd0);
        check("reset_done", {63'd0, done8}, 64'd0);
        check("reset_s", {48'd0, s8}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            op8(vecs[v].sm, vecs[v].a, vecs[v].b, s, lat, nbusy, ndone);
            if (lat < 0) begin
                check($sformatf("vec%0d_timeout", v), 64'd0, 64'd1);
            end else begin
                check($sformatf("vec%0d_s", v), {48'd0, s}, {48'd0, vecs[v].s});
                check($sformatf("vec%0d_latency", v), 64'(lat), 64'd9);
                check($sformatf("vec%0d_busy_cycles", v), 64'(nbusy), 64'd10);
                check($sformatf("vec%0d_done_cycles", v), 64'(ndone), 64'd1);
                check($sformatf("vec%0d_s_hold", v), {48'd0, s8}, {48'd0, vecs[v].s});
            end
        end

        // start pulsed mid-calculation is ignored
        @(negedge clk);
        sm8 = 1'b0; a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'd7; b8 = 8'd7; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dones = 0;
        repeat (20) begin
            if (done8) dones++;
            @(negedge clk);
        end
        check("midcalc_done_count", 64'(dones), 64'd1);
        check("midcalc_s", {48'd0, s8}, 64'd15);

        // start held high: not taken in DONE, taken again in IDLE
        @(negedge clk);
        sm8 = 1'b0; a8 = 8'd2; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'd4;
        first = -1; second = -1; bz10 = 1'bx; bz11 = 1'bx;
        s_first = '0; s_second = '0;
        for (int i = 0; i < 30; i++) begin
            if (done8) begin
                if (first < 0) begin
                    first = i; s_first = s8;
                end else if (second < 0) begin
                    second = i; s_second = s8;
                end
            end
            if (i == 10) bz10 = busy8;
            if (i == 11) bz11 = busy8;
            @(negedge clk);
        end
        start8 = 1'b0;
        repeat (14) @(negedge clk);
        check("held_first_done", 64'(first), 64'd9);
        check("held_first_s", {48'd0, s_first}, 64'd6);
        check("held_idle_gap_busy", {63'd0, bz10}, 64'd0);
        check("held_reaccept_busy", {63'd0, bz11}, 64'd1);
        check("held_second_done", 64'(second), 64'd20);
        check("held_second_s", {48'd0, s_second}, 64'd12);

        // asynchronous reset in the middle of a calculation
        @(negedge clk);
        sm8 = 1'b0; a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {63'd0, busy8}, 64'd0);
        check("midreset_done", {63'd0, done8}, 64'd0);
        check("midreset_s", {48'd0, s8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op8(1'b0, 8'd12, 8'd10, s, lat, nbusy, ndone);
        check("post_reset_s", {48'd0, s}, 64'd120);
        check("post_reset_latency", 64'(lat), 64'd9);

        // N=4 exhaustive, both modes
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    op_gen(4, m[0], 32'(a), 32'(b), sg, got);
                    if (!got) begin
                        check($sformatf("n4_timeout_m%0d_a%0d_b%0d", m, a, b), 64'd0, 64'd1);
                    end else begin
                        check($sformatf("n4_m%0d_a%0d_b%0d", m, a, b), sg,
                              ref_mul(4, m[0], 32'(a), 32'(b)));
                    end
                end
            end
        end

        // N=16 and N=32 smoke tests, including extremes
        for (int k = 0; k < 12; k++) begin
            ra = (k == 0) ? 32'hFFFF_FFFF : (k == 1) ? 32'h8000_0000 : $urandom;
            rb = (k == 0) ? 32'hFFFF_FFFF : (k == 1) ? 32'h8000_0000 : $urandom;
            op_gen(16, k[0], ra, rb, sg, got);
            if (!got) check($sformatf("n16_timeout_%0d", k), 64'd0, 64'd1);
            else check($sformatf("n16_%0d", k), sg, ref_mul(16, k[0], ra, rb));
            op_gen(32, k[0], ra, rb, sg, got);
            if (!got) check($sformatf("n32_timeout_%0d", k), 64'd0, 64'd1);
            else check($sformatf("n32_%0d", k), sg, ref_mul(32, k[0], ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
